// File: rtl/reorder_buffer_if.sv
// Shared width definitions and the dispatch/writeback/commit bundle around the reorder buffer.
// The master side is the pipeline (dispatch, execute, commit); the slave side is the ROB.
package general_defines;
    localparam int unsigned ROB_IDX_W       = 3;
    localparam int unsigned INSTR_MEM_IDX_W = 8;
    localparam int unsigned ARCH_REG_IDX_W  = 5;
    localparam int unsigned PHYS_REG_IDX_W  = 6;
    localparam int unsigned INT_DATA_W      = 32;
endpackage

interface reorder_buffer_if;
    import general_defines::*;

    logic                       alloc_valid;
    logic                       alloc_ready;
    logic [ROB_IDX_W-1:0]       alloc_idx;
    logic [INSTR_MEM_IDX_W-1:0] alloc_pc;
    logic [ARCH_REG_IDX_W-1:0]  alloc_logical_rd;
    logic [PHYS_REG_IDX_W-1:0]  alloc_phys_rd;
    logic [PHYS_REG_IDX_W-1:0]  alloc_old_phys_rd;
    logic                       alloc_is_store;
    logic                       alloc_is_branch;
    logic                       alloc_pred_taken;
    logic [INSTR_MEM_IDX_W-1:0] alloc_pred_target;

    logic                       wb_valid;
    logic [ROB_IDX_W-1:0]       wb_idx;
    logic [INT_DATA_W-1:0]      wb_result;
    logic                       wb_branch_taken;
    logic [INSTR_MEM_IDX_W-1:0] wb_branch_target;

    logic [ROB_IDX_W-1:0]       rob_head_idx;
    logic                       rob_head_valid;
    logic                       rob_head_done;
    logic [INSTR_MEM_IDX_W-1:0] rob_head_pc;
    logic [ARCH_REG_IDX_W-1:0]  rob_head_logical_rd;
    logic [PHYS_REG_IDX_W-1:0]  rob_head_phys_rd;
    logic [PHYS_REG_IDX_W-1:0]  rob_head_old_phys_rd;
    logic                       rob_head_is_store;
    logic                       rob_head_is_branch;
    logic                       rob_head_pred_taken;
    logic [INSTR_MEM_IDX_W-1:0] rob_head_pred_target;
    logic [INT_DATA_W-1:0]      rob_head_result;
    logic                       rob_head_branch_taken;
    logic [INSTR_MEM_IDX_W-1:0] rob_head_branch_target;

    logic                       rob_advance_head;
    logic                       flush_pipeline;
    logic                       rob_empty;
    logic                       rob_full;

    modport master (
        output alloc_valid, alloc_pc, alloc_logical_rd, alloc_phys_rd, alloc_old_phys_rd,
               alloc_is_store, alloc_is_branch, alloc_pred_taken, alloc_pred_target,
               wb_valid, wb_idx, wb_result, wb_branch_taken, wb_branch_target,
               rob_advance_head, flush_pipeline,
        input  alloc_ready, alloc_idx, rob_head_idx, rob_head_valid, rob_head_done,
               rob_head_pc, rob_head_logical_rd, rob_head_phys_rd, rob_head_old_phys_rd,
               rob_head_is_store, rob_head_is_branch, rob_head_pred_taken, rob_head_pred_target,
               rob_head_result, rob_head_branch_taken, rob_head_branch_target,
               rob_empty, rob_full
    );

    modport slave (
        input  alloc_valid, alloc_pc, alloc_logical_rd, alloc_phys_rd, alloc_old_phys_rd,
               alloc_is_store, alloc_is_branch, alloc_pred_taken, alloc_pred_target,
               wb_valid, wb_idx, wb_result, wb_branch_taken, wb_branch_target,
               rob_advance_head, flush_pipeline,
        output alloc_ready, alloc_idx, rob_head_idx, rob_head_valid, rob_head_done,
               rob_head_pc, rob_head_logical_rd, rob_head_phys_rd, rob_head_old_phys_rd,
               rob_head_is_store, rob_head_is_branch, rob_head_pred_taken, rob_head_pred_target,
               rob_head_result, rob_head_branch_taken, rob_head_branch_target,
               rob_empty, rob_full
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocation at the tail, out-of-order completion,
// in-order retirement from the head, and a single-cycle flush.
module reorder_buffer
    import general_defines::*;
#(
    parameter int unsigned ROB_DEPTH = 2**ROB_IDX_W
) (
    input  logic            clk,
    input  logic            rst,
    reorder_buffer_if.slave rob
);
    localparam int unsigned          CNT_W   = ROB_IDX_W + 1;
    localparam logic [CNT_W-1:0]     DEPTH_C = CNT_W'(ROB_DEPTH);
    localparam logic [ROB_IDX_W-1:0] LAST_C  = ROB_IDX_W'(ROB_DEPTH - 1);

    typedef struct packed {
        logic [INSTR_MEM_IDX_W-1:0] pc;
        logic [ARCH_REG_IDX_W-1:0]  logical_rd;
        logic [PHYS_REG_IDX_W-1:0]  phys_rd;
        logic [PHYS_REG_IDX_W-1:0]  old_phys_rd;
        logic                       is_store;
        logic                       is_branch;
        logic                       pred_taken;
        logic [INSTR_MEM_IDX_W-1:0] pred_target;
        logic [INT_DATA_W-1:0]      result;
        logic                       branch_taken;
        logic [INSTR_MEM_IDX_W-1:0] branch_target;
    } payload_t;

    logic [ROB_IDX_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [ROB_DEPTH-1:0] valid_q, valid_d, done_q, done_d;
    payload_t             ent_q [ROB_DEPTH];
    payload_t             ent_d [ROB_DEPTH];
    payload_t             head_ent;
    logic                 do_alloc, do_wb, do_adv, wb_in_range;

    function automatic logic [ROB_IDX_W-1:0] wrap_inc(input logic [ROB_IDX_W-1:0] p);
        return (p == LAST_C) ? '0 : p + ROB_IDX_W'(1);
    endfunction

    assign head_ent = ent_q[head_q];

    always_comb begin
        rob.alloc_ready            = (count_q != DEPTH_C) && !rob.flush_pipeline;
        rob.alloc_idx              = tail_q;
        rob.rob_full               = (count_q == DEPTH_C);
        rob.rob_empty              = (count_q == '0);
        rob.rob_head_idx           = head_q;
        rob.rob_head_valid         = (count_q != '0) && valid_q[head_q];
        rob.rob_head_done          = rob.rob_head_valid && done_q[head_q];
        rob.rob_head_pc            = head_ent.pc;
        rob.rob_head_logical_rd    = head_ent.logical_rd;
        rob.rob_head_phys_rd       = head_ent.phys_rd;
        rob.rob_head_old_phys_rd   = head_ent.old_phys_rd;
        rob.rob_head_is_store      = head_ent.is_store;
        rob.rob_head_is_branch     = head_ent.is_branch;
        rob.rob_head_pred_taken    = head_ent.pred_taken;
        rob.rob_head_pred_target   = head_ent.pred_target;
        rob.rob_head_result        = head_ent.result;
        rob.rob_head_branch_taken  = head_ent.branch_taken;
        rob.rob_head_branch_target = head_ent.branch_target;
    end

    always_comb begin
        // NOTE: every _d starts from its _q so no path through this block can infer a latch.
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        done_d  = done_q;
        ent_d   = ent_q;

        wb_in_range = CNT_W'(rob.wb_idx) < DEPTH_C;
        do_alloc    = rob.alloc_valid && rob.alloc_ready;
        do_wb       = rob.wb_valid && wb_in_range && valid_q[rob.wb_idx] && !rob.flush_pipeline;
        // Advance sees the pre-edge done bit, so a same-cycle writeback cannot retire the head.
        do_adv      = rob.rob_advance_head && rob.rob_head_done && !rob.flush_pipeline;

        if (rob.flush_pipeline) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            valid_d = '0;
            done_d  = '0;
        end else begin
            if (do_wb) begin
                done_d[rob.wb_idx]               = 1'b1;
                ent_d[rob.wb_idx].result         = rob.wb_result;
                ent_d[rob.wb_idx].branch_taken   = rob.wb_branch_taken;
                ent_d[rob.wb_idx].branch_target  = rob.wb_branch_target;
            end
            if (do_adv) begin
                valid_d[head_q] = 1'b0;
                done_d[head_q]  = 1'b0;
                head_d          = wrap_inc(head_q);
            end
            if (do_alloc) begin
                valid_d[tail_q]           = 1'b1;
                done_d[tail_q]            = 1'b0;
                ent_d[tail_q].pc          = rob.alloc_pc;
                ent_d[tail_q].logical_rd  = rob.alloc_logical_rd;
                ent_d[tail_q].phys_rd     = rob.alloc_phys_rd;
                ent_d[tail_q].old_phys_rd = rob.alloc_old_phys_rd;
                ent_d[tail_q].is_store    = rob.alloc_is_store;
                ent_d[tail_q].is_branch   = rob.alloc_is_branch;
                ent_d[tail_q].pred_taken  = rob.alloc_pred_taken;
                ent_d[tail_q].pred_target = rob.alloc_pred_target;
                tail_d                    = wrap_inc(tail_q);
            end
            if (do_alloc && !do_adv) begin
                count_d = count_q + CNT_W'(1);
            end else if (do_adv && !do_alloc) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // NOTE: the payload array is deliberately left unreset; valid/done qualify every read.
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a queue-based model checked every cycle on the
// falling edge, plus literal expectations at the interesting points of each scenario.
module tb_reorder_buffer;
    import general_defines::*;

    localparam int DEPTH = 2**ROB_IDX_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reorder_buffer_if rob_bus();

    reorder_buffer #(.ROB_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .rob (rob_bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: an ordered queue of live entries ----------------
    typedef struct {
        int     idx;
        int     pc, lrd, prd, oprd, ptgt;
        bit     st, br, pt;
        bit     done;
        longint result;
        bit     bt;
        int     btgt;
    } mentry_t;

    mentry_t mq[$];
    int      m_head = 0;
    int      m_tail = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_head = 0;
            m_tail = 0;
        end else begin
            bit      acc_alloc, acc_adv;
            mentry_t e;
            acc_alloc = rob_bus.alloc_valid && (mq.size() < DEPTH) && !rob_bus.flush_pipeline;
            acc_adv   = rob_bus.rob_advance_head && (mq.size() > 0) && !rob_bus.flush_pipeline;
            if (acc_adv) acc_adv = mq[0].done;
            if (rob_bus.flush_pipeline) begin
                mq.delete();
                m_head = 0;
                m_tail = 0;
            end else begin
                if (rob_bus.wb_valid) begin
                    foreach (mq[i]) begin
                        if (mq[i].idx == int'(rob_bus.wb_idx)) begin
                            mq[i].done   = 1'b1;
                            mq[i].result = longint'(rob_bus.wb_result);
                            mq[i].bt     = rob_bus.wb_branch_taken;
                            mq[i].btgt   = int'(rob_bus.wb_branch_target);
                        end
                    end
                end
                if (acc_adv) begin
                    void'(mq.pop_front());
                    m_head = (m_head + 1) % DEPTH;
                end
                if (acc_alloc) begin
                    e.idx    = m_tail;
                    e.pc     = int'(rob_bus.alloc_pc);
                    e.lrd    = int'(rob_bus.alloc_logical_rd);
                    e.prd    = int'(rob_bus.alloc_phys_rd);
                    e.oprd   = int'(rob_bus.alloc_old_phys_rd);
                    e.st     = rob_bus.alloc_is_store;
                    e.br     = rob_bus.alloc_is_branch;
                    e.pt     = rob_bus.alloc_pred_taken;
                    e.ptgt   = int'(rob_bus.alloc_pred_target);
                    e.done   = 1'b0;
                    e.result = 0;
                    e.bt     = 1'b0;
                    e.btgt   = 0;
                    mq.push_back(e);
                    m_tail = (m_tail + 1) % DEPTH;
                end
            end
        end
    end

    // ---------------- per-cycle comparison against the model ----------------
    always @(negedge clk) begin
        int sz;
        sz = mq.size();
        check("alloc_ready", rob_bus.alloc_ready, (sz < DEPTH) && !rob_bus.flush_pipeline);
        check("alloc_idx", rob_bus.alloc_idx, m_tail);
        check("head_idx", rob_bus.rob_head_idx, m_head);
        check("rob_empty", rob_bus.rob_empty, sz == 0);
        check("rob_full", rob_bus.rob_full, sz == DEPTH);
        check("head_valid", rob_bus.rob_head_valid, sz > 0);
        if (sz > 0) begin
            check("head_done", rob_bus.rob_head_done, mq[0].done);
            check("head_pc", rob_bus.rob_head_pc, mq[0].pc);
            check("head_lrd", rob_bus.rob_head_logical_rd, mq[0].lrd);
            check("head_prd", rob_bus.rob_head_phys_rd, mq[0].prd);
            check("head_oprd", rob_bus.rob_head_old_phys_rd, mq[0].oprd);
            check("head_flags", {rob_bus.rob_head_is_store, rob_bus.rob_head_is_branch,
                                 rob_bus.rob_head_pred_taken}, {mq[0].st, mq[0].br, mq[0].pt});
            check("head_ptgt", rob_bus.rob_head_pred_target, mq[0].ptgt);
            if (mq[0].done) begin
                check("head_result", rob_bus.rob_head_result, mq[0].result);
                check("head_bt", rob_bus.rob_head_branch_taken, mq[0].bt);
                check("head_btgt", rob_bus.rob_head_branch_target, mq[0].btgt);
            end
        end else begin
            check("head_done_empty", rob_bus.rob_head_done, 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        rob_bus.alloc_valid       = 1'b0;
        rob_bus.alloc_pc          = '0;
        rob_bus.alloc_logical_rd  = '0;
        rob_bus.alloc_phys_rd     = '0;
        rob_bus.alloc_old_phys_rd = '0;
        rob_bus.alloc_is_store    = 1'b0;
        rob_bus.alloc_is_branch   = 1'b0;
        rob_bus.alloc_pred_taken  = 1'b0;
        rob_bus.alloc_pred_target = '0;
        rob_bus.wb_valid          = 1'b0;
        rob_bus.wb_idx            = '0;
        rob_bus.wb_result         = '0;
        rob_bus.wb_branch_taken   = 1'b0;
        rob_bus.wb_branch_target  = '0;
        rob_bus.rob_advance_head  = 1'b0;
        rob_bus.flush_pipeline    = 1'b0;
    endtask

    task automatic set_alloc(input int pc);
        rob_bus.alloc_valid       = 1'b1;
        rob_bus.alloc_pc          = INSTR_MEM_IDX_W'(pc);
        rob_bus.alloc_logical_rd  = ARCH_REG_IDX_W'(pc + 1);
        rob_bus.alloc_phys_rd     = PHYS_REG_IDX_W'(pc * 3);
        rob_bus.alloc_old_phys_rd = PHYS_REG_IDX_W'(pc + 7);
        rob_bus.alloc_is_store    = pc[0];
        rob_bus.alloc_is_branch   = pc[1];
        rob_bus.alloc_pred_taken  = pc[2];
        rob_bus.alloc_pred_target = INSTR_MEM_IDX_W'(pc + 4);
    endtask

    task automatic set_wb(input int idx, input int result, input bit taken, input int target);
        rob_bus.wb_valid         = 1'b1;
        rob_bus.wb_idx           = ROB_IDX_W'(idx);
        rob_bus.wb_result        = INT_DATA_W'(result);
        rob_bus.wb_branch_taken  = taken;
        rob_bus.wb_branch_target = INSTR_MEM_IDX_W'(target);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int commit_pc[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1'b0;
        #2;
        check("reset alloc_ready", rob_bus.alloc_ready, 1);
        check("reset alloc_idx", rob_bus.alloc_idx, 0);
        check("reset head_valid", rob_bus.rob_head_valid, 0);
        check("reset head_done", rob_bus.rob_head_done, 0);
        check("reset empty", rob_bus.rob_empty, 1);
        check("reset full", rob_bus.rob_full, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Allocate pc 10, 11, 12 into indices 0, 1, 2.
        for (int i = 0; i < 3; i++) begin
            set_alloc(10 + i);
            #1;
            check("alloc_idx seq", rob_bus.alloc_idx, i);
            tick();
        end
        idle();
        #1;
        check("lit head_valid", rob_bus.rob_head_valid, 1);
        check("lit head_done", rob_bus.rob_head_done, 0);
        check("lit head_pc", rob_bus.rob_head_pc, 10);

        // Out-of-order completion: idx1 first, head becomes done only after idx0.
        set_wb(1, 32'h55, 1'b1, 8'h33);
        tick();
        idle();
        #1;
        check("lit head_done after wb1", rob_bus.rob_head_done, 0);
        set_wb(0, 32'hAA, 1'b0, 0);
        tick();
        idle();
        #1;
        check("lit head_done after wb0", rob_bus.rob_head_done, 1);
        rob_bus.rob_advance_head = 1'b1;
        tick();
        idle();
        #1;
        check("lit head_idx after adv", rob_bus.rob_head_idx, 1);
        check("lit head_done idx1", rob_bus.rob_head_done, 1);
        check("lit head_result idx1", rob_bus.rob_head_result, 32'h55);
        check("lit head_bt idx1", rob_bus.rob_head_branch_taken, 1);

        // Fill to capacity: 2 live entries + 6 more, tail wraps to 1.
        for (int i = 0; i < DEPTH - 2; i++) begin
            set_alloc(20 + i);
            tick();
        end
        idle();
        #1;
        check("lit full", rob_bus.rob_full, 1);
        check("lit alloc_ready full", rob_bus.alloc_ready, 0);
        set_alloc(99);
        tick();
        idle();
        #1;
        check("lit dropped alloc_idx", rob_bus.alloc_idx, 1);
        check("lit still full", rob_bus.rob_full, 1);
        set_alloc(98);
        rob_bus.rob_advance_head = 1'b1;
        #1;
        check("lit no bypass", rob_bus.alloc_ready, 0);
        tick();
        idle();
        #1;
        check("lit alloc_ready after adv", rob_bus.alloc_ready, 1);
        check("lit full after adv", rob_bus.rob_full, 0);
        check("lit head_idx 2", rob_bus.rob_head_idx, 2);

        // Retire two more so five entries remain, then flush with concurrent alloc/wb.
        set_wb(2, 32'h222, 1'b0, 0);
        tick();
        idle();
        set_wb(3, 32'h333, 1'b1, 8'h44);
        rob_bus.rob_advance_head = 1'b1;
        tick();
        idle();
        rob_bus.rob_advance_head = 1'b1;
        tick();
        idle();
        #1;
        check("lit head_idx 4", rob_bus.rob_head_idx, 4);
        set_alloc(50);
        set_wb(4, 32'h444, 1'b0, 0);
        rob_bus.flush_pipeline = 1'b1;
        #1;
        check("lit alloc_ready flush", rob_bus.alloc_ready, 0);
        tick();
        idle();
        #1;
        check("lit flush empty", rob_bus.rob_empty, 1);
        check("lit flush head_idx", rob_bus.rob_head_idx, 0);
        check("lit flush alloc_idx", rob_bus.alloc_idx, 0);
        check("lit flush head_valid", rob_bus.rob_head_valid, 0);

        // Writeback to the head in the same cycle as advance must not retire it.
        set_alloc(200);
        tick();
        idle();
        set_wb(0, 32'h1234, 1'b0, 0);
        rob_bus.rob_advance_head = 1'b1;
        tick();
        idle();
        #1;
        check("lit wb+adv head_valid", rob_bus.rob_head_valid, 1);
        check("lit wb+adv head_idx", rob_bus.rob_head_idx, 0);
        check("lit wb+adv head_done", rob_bus.rob_head_done, 1);
        rob_bus.rob_advance_head = 1'b1;
        tick();
        idle();
        #1;
        check("lit retire empty", rob_bus.rob_empty, 1);
        check("lit retire head_idx", rob_bus.rob_head_idx, 1);
        rob_bus.flush_pipeline = 1'b1;
        tick();
        idle();

        // Streaming alloc/complete/commit of 2*DEPTH instructions from index 0.
        commit_pc.delete();
        for (int k = 0; k < 2 * DEPTH + 3; k++) begin
            idle();
            if (k < 2 * DEPTH) set_alloc(100 + k);
            if (k >= 1 && k <= 2 * DEPTH) set_wb((k - 1) % DEPTH, 1000 + k, 1'b0, 0);
            rob_bus.rob_advance_head = 1'b1;
            #1;
            if (rob_bus.rob_head_done) commit_pc.push_back(int'(rob_bus.rob_head_pc));
            tick();
        end
        idle();
        #1;
        check("stream commit count", commit_pc.size(), 2 * DEPTH);
        for (int i = 0; i < commit_pc.size() && i < 2 * DEPTH; i++) begin
            check("stream commit pc", commit_pc[i], 100 + i);
        end
        check("stream head wrap", rob_bus.rob_head_idx, 0);
        check("stream tail wrap", rob_bus.alloc_idx, 0);
        check("stream empty", rob_bus.rob_empty, 1);

        // Asynchronous reset in mid-cycle.
        set_alloc(70);
        tick();
        set_alloc(71);
        tick();
        idle();
        #1;
        check("lit pre-reset head_valid", rob_bus.rob_head_valid, 1);
        #1;
        rst = 1'b0;
        #1;
        check("async alloc_ready", rob_bus.alloc_ready, 1);
        check("async alloc_idx", rob_bus.alloc_idx, 0);
        check("async head_valid", rob_bus.rob_head_valid, 0);
        check("async head_done", rob_bus.rob_head_done, 0);
        check("async empty", rob_bus.rob_empty, 1);
        check("async full", rob_bus.rob_full, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
